freq_sweep_ctrl: RTL and testbench
==================================

FREQ_SWEEP_CTRL -- requirements
Module: freq_sweep_ctrl

Interface
REQ-001 Parameter DEF_FREQ, default 50: out_freq value after reset (Hz).
REQ-002 Parameter DEF_DISCR, default 8000: discr_freq value after reset (Hz).
REQ-003 Parameter IDX_W, default 16: width of step_idx.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with ports named as follows.
REQ-005 clk  input  1  system clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  request a sweep; sampled only in IDLE.
REQ-008 abort  input  1  cancel a sweep in progress.
REQ-009 f_start  input  32  first frequency (Hz).
REQ-010 f_stop  input  32  frequency limit (Hz).
REQ-011 f_step  input  32  frequency increment (Hz).
REQ-012 dwell  input  32  clk cycles held per frequency.
REQ-013 discr_cfg  input  32  sample rate to drive (Hz).
REQ-014 out_freq  output  32  frequency word to the CORDIC generator.
REQ-015 discr_freq  output  32  sample-rate word to the CORDIC generator.
REQ-016 busy  output  1  high while a sweep runs (DWELL state).
REQ-017 done  output  1  one-cycle pulse at sweep end or on config reject.
REQ-018 err  output  1  valid with done: 1 means config rejected.
REQ-019 step_strobe  output  1  one-cycle pulse when out_freq takes a new sweep value.
REQ-020 step_idx  output  IDX_W  index of the current step; 0 is the first.

Function
REQ-021 The FSM SHALL have states IDLE, DWELL and DONE.
- IDLE -> DWELL on a valid start.
- IDLE -> DONE on an invalid start.
- DWELL -> DONE at the end of the last step.
- DWELL -> IDLE on abort.
- DONE -> IDLE unconditionally after one cycle.
REQ-022 A start in IDLE SHALL latch f_start, f_stop, f_step, dwell and discr_cfg internally; later changes on these inputs SHALL have no effect until the next start.
REQ-023 The config SHALL be invalid if any of these holds: f_step==0, dwell==0, f_start>f_stop, or 2*f_stop>discr_cfg (33-bit compare).
REQ-024 On an invalid start, out_freq, discr_freq and step_idx SHALL be unchanged, and done=1 with err=1 SHALL be asserted for exactly one cycle.
REQ-025 On the edge that samples a valid start, the block SHALL load:
- out_freq<=f_start, discr_freq<=discr_cfg, step_idx<=0;
- dwell counter<=0; busy<=1; step_strobe<=1 for the following cycle.
REQ-026 In DWELL, the dwell counter SHALL increment each cycle; every frequency value SHALL be held for exactly dwell cycles.
REQ-027 When counter==dwell-1 and out_freq+f_step<=f_stop, the block SHALL, on that edge:
- set out_freq<=out_freq+f_step and step_idx<=step_idx+1;
- clear the counter and pulse step_strobe.
The sum SHALL be computed at 33 bits so it cannot wrap.
REQ-028 When counter==dwell-1 and out_freq+f_step>f_stop (33-bit), the FSM SHALL enter DONE. The sweep therefore ends at the last value <=f_stop, with no clamping to f_stop.
REQ-029 In DONE, the block SHALL hold done=1, err=0 and busy=0 for exactly one cycle.
REQ-030 Total busy cycles SHALL be N*dwell, where N=floor((f_stop-f_start)/f_step)+1.
REQ-031 step_idx SHALL saturate at its all-ones value and never wrap.
REQ-032 After a sweep ends or aborts, out_freq and discr_freq SHALL hold their last values so the generator keeps running.
REQ-033 abort in DWELL SHALL take effect on the next edge:
- state goes to IDLE and busy goes to 0;
- done, err and step_strobe stay 0;
- abort overrides a step update on the same edge.
REQ-034 In IDLE, abort together with start SHALL do nothing; abort wins.
REQ-035 start while busy or in DONE SHALL be ignored.
REQ-036 done, err and step_strobe SHALL be registered outputs and SHALL be 0 in every cycle not specified above.

Reset
REQ-037 While rst_n=0, independent of clk, the block SHALL force:
- state=IDLE;
- out_freq=DEF_FREQ, discr_freq=DEF_DISCR;
- busy=0, done=0, err=0, step_strobe=0, step_idx=0, dwell counter=0.
REQ-038 Reset mid-sweep SHALL discard all latched config; the first valid start after rst_n rises SHALL behave exactly as in REQ-025.

Verification
REQ-039 f_start=50, f_stop=200, f_step=50, dwell=4, discr_cfg=8000, start pulse -> out_freq 50,100,150,200 for 4 cycles each; step_idx 0..3; 4 step_strobe pulses; busy high for 16 cycles; then done=1, err=0 for one cycle; out_freq holds 200.
REQ-040 f_start=100, f_stop=250, f_step=100, dwell=3 -> out_freq 100 then 200; 6 busy cycles; done pulse; 300 never appears.
REQ-041 f_step=0 -> done=1, err=1 for one cycle, busy stays 0, outputs unchanged; separately, f_stop=4001 with discr_cfg=8000 -> same reject response.
REQ-042 Sweep 50..200 step 50, dwell=4, abort in cycle 6 -> out_freq holds 100, busy falls next edge, no done pulse; start asserted in the same cycle as abort is ignored.
REQ-043 f_start=0x7FFFFFF0, f_stop=0x7FFFFFFF, f_step=0x40000000, dwell=2, discr_cfg=0xFFFFFFFF -> single step at 0x7FFFFFF0 (no 32-bit wrap); done after 2 busy cycles.
REQ-044 Sweep running, rst_n pulled low between clk edges -> outputs immediately at reset values (out_freq=50, discr_freq=8000); after release, a new valid start behaves as in REQ-039.

Source files
------------

// File: rtl/freq_sweep_ctrl.sv
// Frequency sweep controller: steps a frequency word for a CORDIC generator
// from f_start towards f_stop, holding each value for a programmable dwell.
module freq_sweep_ctrl #(
  parameter logic [31:0] DEF_FREQ  = 32'd50,
  parameter logic [31:0] DEF_DISCR = 32'd8000,
  parameter int          IDX_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      f_start,
  input  logic [31:0]      f_stop,
  input  logic [31:0]      f_step,
  input  logic [31:0]      dwell,
  input  logic [31:0]      discr_cfg,
  output logic [31:0]      out_freq,
  output logic [31:0]      discr_freq,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             step_strobe,
  output logic [IDX_W-1:0] step_idx,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DWELL = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state, w_state;
  logic [31:0]      r_out_freq, w_out_freq;
  logic [31:0]      r_discr_freq, w_discr_freq;
  logic             r_busy, w_busy;
  logic             r_done, w_done;
  logic             r_err, w_err;
  logic             r_strobe, w_strobe;
  logic [IDX_W-1:0] r_idx, w_idx;
  logic [31:0]      r_cnt, w_cnt;
  logic [31:0]      r_stop, w_stop;
  logic [31:0]      r_step, w_step;
  logic [31:0]      r_dwell, w_dwell;

  logic             w_cfg_bad;
  logic [32:0]      w_sum;
  logic             w_last;

  // Widened compares so neither the doubled stop nor the next frequency can wrap.
  assign w_cfg_bad = (f_step == 32'd0) || (dwell == 32'd0) || (f_start > f_stop) ||
                     ({f_stop, 1'b0} > {1'b0, discr_cfg});
  assign w_sum     = {1'b0, r_out_freq} + {1'b0, r_step};
  assign w_last    = (r_cnt == (r_dwell - 32'd1));

  always_comb begin
    w_state      = r_state;
    w_out_freq   = r_out_freq;
    w_discr_freq = r_discr_freq;
    w_busy       = r_busy;
    w_done       = 1'b0;
    w_err        = 1'b0;
    w_strobe     = 1'b0;
    w_idx        = r_idx;
    w_cnt        = r_cnt;
    w_stop       = r_stop;
    w_step       = r_step;
    w_dwell      = r_dwell;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          if (w_cfg_bad) begin
            w_state = S_DONE;
            w_done  = 1'b1;
            w_err   = 1'b1;
          end else begin
            w_state      = S_DWELL;
            w_out_freq   = f_start;
            w_discr_freq = discr_cfg;
            w_idx        = '0;
            w_cnt        = 32'd0;
            w_busy       = 1'b1;
            w_strobe     = 1'b1;
            w_stop       = f_stop;
            w_step       = f_step;
            w_dwell      = dwell;
          end
        end
      end
      S_DWELL: begin
        if (abort) begin
          w_state = S_IDLE;
          w_busy  = 1'b0;
          w_cnt   = 32'd0;
        end else if (w_last) begin
          w_cnt = 32'd0;
          if (w_sum <= {1'b0, r_stop}) begin
            w_out_freq = w_sum[31:0];
            w_idx      = (&r_idx) ? r_idx : r_idx + 1'b1;
            w_strobe   = 1'b1;
          end else begin
            w_state = S_DONE;
            w_busy  = 1'b0;
            w_done  = 1'b1;
          end
        end else begin
          w_cnt = r_cnt + 32'd1;
        end
      end
      S_DONE:  w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_out_freq   <= DEF_FREQ;
      r_discr_freq <= DEF_DISCR;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_strobe     <= 1'b0;
      r_idx        <= '0;
      r_cnt        <= 32'd0;
      r_stop       <= 32'd0;
      r_step       <= 32'd0;
      r_dwell      <= 32'd0;
    end else begin
      r_state      <= w_state;
      r_out_freq   <= w_out_freq;
      r_discr_freq <= w_discr_freq;
      r_busy       <= w_busy;
      r_done       <= w_done;
      r_err        <= w_err;
      r_strobe     <= w_strobe;
      r_idx        <= w_idx;
      r_cnt        <= w_cnt;
      r_stop       <= w_stop;
      r_step       <= w_step;
      r_dwell      <= w_dwell;
    end
  end

  assign out_freq    = r_out_freq;
  assign discr_freq  = r_discr_freq;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;
  assign step_strobe = r_strobe;
  assign step_idx    = r_idx;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Bench for freq_sweep_ctrl: closed-form sweep model checked every cycle,
// plus hand-computed totals per directed scenario.
module tb_freq_sweep_ctrl;

  localparam int IDX_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start, abort;
  logic [31:0]      f_start, f_stop, f_step, dwell, discr_cfg;
  logic [31:0]      out_freq, discr_freq;
  logic             busy, done, err, step_strobe;
  logic [IDX_W-1:0] step_idx;
  logic [1:0]       dbg_state;

  freq_sweep_ctrl #(.DEF_FREQ(32'd50), .DEF_DISCR(32'd8000), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell),
    .discr_cfg(discr_cfg), .out_freq(out_freq), .discr_freq(discr_freq),
    .busy(busy), .done(done), .err(err), .step_strobe(step_strobe),
    .step_idx(step_idx), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cnt_busy, cnt_strobe, cnt_done, cnt_err;
  logic [31:0] exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: output values follow from the number of cycles elapsed since the start.
  logic [63:0] m_start, m_stop, m_step, m_dwell, m_n, m_k, m_blk;
  bit          m_active, m_in_done;
  logic [31:0] e_out, e_discr;
  logic        e_busy, e_done, e_err, e_strobe;
  logic [IDX_W-1:0] e_idx;

  task automatic model_reset();
    m_active = 0; m_in_done = 0;
    e_out = 32'd50; e_discr = 32'd8000; e_idx = '0;
    e_busy = 0; e_done = 0; e_err = 0; e_strobe = 0;
  endtask

  task automatic model_step();
    e_done = 0; e_err = 0; e_strobe = 0;
    if (m_active) begin
      if (abort) begin
        m_active = 0; e_busy = 0;
      end else begin
        m_k++;
        if (m_k == m_n * m_dwell) begin
          m_active = 0; e_busy = 0; e_done = 1; m_in_done = 1;
        end else begin
          m_blk    = m_k / m_dwell;
          e_out    = 32'(m_start + m_blk * m_step);
          e_idx    = (m_blk > 64'(2**IDX_W - 1)) ? '1 : IDX_W'(m_blk);
          e_strobe = ((m_k % m_dwell) == 0);
        end
      end
    end else if (m_in_done) begin
      m_in_done = 0;
    end else if (start && !abort) begin
      if (f_step == 0 || dwell == 0 || f_start > f_stop ||
          2 * {32'd0, f_stop} > {32'd0, discr_cfg}) begin
        e_done = 1; e_err = 1; m_in_done = 1;
      end else begin
        m_start = {32'd0, f_start}; m_stop = {32'd0, f_stop};
        m_step  = {32'd0, f_step};  m_dwell = {32'd0, dwell};
        m_n = (m_stop - m_start) / m_step + 1;
        m_k = 0; m_active = 1;
        e_out = f_start; e_discr = discr_cfg; e_idx = '0;
        e_busy = 1; e_strobe = 1;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Compare process: one sample per cycle, 1 time unit after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("out_freq",    {32'd0, out_freq},   {32'd0, e_out});
      chk("discr_freq",  {32'd0, discr_freq}, {32'd0, e_discr});
      chk("busy",        {63'd0, busy},        {63'd0, e_busy});
      chk("done",        {63'd0, done},        {63'd0, e_done});
      chk("err",         {63'd0, err},         {63'd0, e_err});
      chk("step_strobe", {63'd0, step_strobe}, {63'd0, e_strobe});
      chk("step_idx",    64'(step_idx),        64'(e_idx));
      chk("dbg_known",   {63'd0, $isunknown(dbg_state)}, 64'd0);
      if (busy === 1'b1) cnt_busy++;
      if (step_strobe === 1'b1) begin
        cnt_strobe++;
        if (exp_q.size() > 0) chk("strobe_freq", {32'd0, out_freq}, {32'd0, exp_q.pop_front()});
      end
      if (done === 1'b1) cnt_done++;
      if (err === 1'b1) cnt_err++;
    end
  end

  task automatic set_cfg(input logic [31:0] a, b, c, d, e);
    f_start = a; f_stop = b; f_step = c; dwell = d; discr_cfg = e;
  endtask

  task automatic clear_counts();
    cnt_busy = 0; cnt_strobe = 0; cnt_done = 0; cnt_err = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_totals(input string nm, input int b, s, d, e);
    chk({nm, "_busy_cycles"}, 64'(cnt_busy),   64'(b));
    chk({nm, "_strobes"},     64'(cnt_strobe), 64'(s));
    chk({nm, "_dones"},       64'(cnt_done),   64'(d));
    chk({nm, "_errs"},        64'(cnt_err),    64'(e));
  endtask

  task automatic run_basic_sweep(input string nm);
    set_cfg(32'd50, 32'd200, 32'd50, 32'd4, 32'd8000);
    exp_q = '{32'd50, 32'd100, 32'd150, 32'd200};
    clear_counts();
    pulse_start();
    wait_cyc(3);
    set_cfg(32'd10, 32'd20, 32'd5, 32'd2, 32'd8000);
    start = 1'b1;
    wait_cyc(2);
    start = 1'b0;
    wait_cyc(11);
    start = 1'b1;
    wait_cyc(1);
    start = 1'b0;
    wait_cyc(4);
    check_totals(nm, 16, 4, 1, 0);
    chk({nm, "_final_freq"}, {32'd0, out_freq}, 64'd200);
    chk({nm, "_final_idx"},  64'(step_idx), 64'd3);
    chk({nm, "_queue_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    set_cfg(32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    clear_counts();
    wait_cyc(3);
    chk("reset_out_freq",   {32'd0, out_freq},   64'd50);
    chk("reset_discr_freq", {32'd0, discr_freq}, 64'd8000);
    rst_n = 1'b1;
    wait_cyc(2);

    run_basic_sweep("sweep50");

    set_cfg(32'd100, 32'd250, 32'd100, 32'd3, 32'd8000);
    clear_counts();
    pulse_start();
    wait_cyc(10);
    check_totals("sweep100", 6, 2, 1, 0);
    chk("sweep100_final_freq", {32'd0, out_freq}, 64'd200);

    set_cfg(32'd50, 32'd200, 32'd0, 32'd4, 32'd8000);
    clear_counts();
    pulse_start();
    wait_cyc(3);
    check_totals("rej_step0", 0, 0, 1, 1);
    chk("rej_step0_freq", {32'd0, out_freq}, 64'd200);

    set_cfg(32'd50, 32'd4001, 32'd50, 32'd4, 32'd8000);
    clear_counts();
    pulse_start();
    wait_cyc(3);
    check_totals("rej_nyq", 0, 0, 1, 1);
    chk("rej_nyq_freq", {32'd0, out_freq}, 64'd200);

    set_cfg(32'd50, 32'd200, 32'd50, 32'd0, 32'd8000);
    clear_counts();
    pulse_start();
    wait_cyc(3);
    check_totals("rej_dwell0", 0, 0, 1, 1);

    set_cfg(32'd4000, 32'd4000, 32'd1, 32'd1, 32'd8000);
    clear_counts();
    pulse_start();
    wait_cyc(3);
    check_totals("edge_nyq", 1, 1, 1, 0);
    chk("edge_nyq_freq", {32'd0, out_freq}, 64'd4000);

    set_cfg(32'd50, 32'd200, 32'd50, 32'd4, 32'd8000);
    clear_counts();
    pulse_start();
    wait_cyc(5);
    abort = 1'b1; start = 1'b1;
    wait_cyc(2);
    abort = 1'b0; start = 1'b0;
    wait_cyc(6);
    check_totals("abort", 6, 2, 0, 0);
    chk("abort_freq", {32'd0, out_freq}, 64'd100);

    set_cfg(32'h7FFF_FFF0, 32'h7FFF_FFFF, 32'h4000_0000, 32'd2, 32'hFFFF_FFFF);
    clear_counts();
    pulse_start();
    wait_cyc(5);
    check_totals("nowrap", 2, 1, 1, 0);
    chk("nowrap_freq",  {32'd0, out_freq},   64'h7FFF_FFF0);
    chk("nowrap_discr", {32'd0, discr_freq}, 64'hFFFF_FFFF);

    set_cfg(32'd50, 32'd200, 32'd50, 32'd4, 32'd8000);
    clear_counts();
    pulse_start();
    wait_cyc(5);
    chk("pre_rst_freq", {32'd0, out_freq}, 64'd100);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_freq",  {32'd0, out_freq},   64'd50);
    chk("async_rst_discr", {32'd0, discr_freq}, 64'd8000);
    chk("async_rst_busy",  {63'd0, busy},       64'd0);
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(2);

    run_basic_sweep("after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
